clip_mem_sequencer: RTL and testbench
=====================================

// Module: clip_mem_sequencer
// PURPOSE
// Responder to the recorder controller's session outputs. While timer=1, moves audio samples
// between the deserializer and clip memory (record) or clip memory and the serializer (play).
// Addresses the selected clip block and returns a one-cycle seconds2 pulse to the controller
// after exactly CLIP_SAMPLES samples, i.e. 2 s at the sample rate.
// PARAMETERS
// DATA_W        8      sample width, bits
// OFS_W         14     per-clip offset width; clip block b occupies addresses {b, 0..CLIP_SAMPLES-1}
// CLIP_SAMPLES  16000  samples per clip (2 s @ 8 kHz); must be in 1..2**OFS_W
// PORTS
// clock                  in   1        rising-edge clock, sole clock domain
// reset_n                in   1        synchronous reset, active-low
// timer                  in   1        session active (from controller)
// memoryselect_clip_1    in   2        [1]=clip block, [0]=1 write/record, 0 read/play
// seriena                in   1        play session enable
// deseriena              in   1        record session enable
// des_valid / des_ready  in/out 1      deserializer->sequencer sample handshake
// des_data               in   DATA_W   sample from deserializer
// ser_valid / ser_ready  out/in 1      sequencer->serializer sample handshake
// ser_data               out  DATA_W   sample to serializer
// mem_addr               out  OFS_W+1  {block, offset}
// mem_we / mem_wdata     out  1/DATA_W write strobe and data
// mem_re / mem_rdata     out/in 1/DATA_W read strobe; rdata valid exactly 1 cycle after mem_re
// seconds2               out  1        1-cycle pulse: clip complete
// seq_err                out  1        sticky: illegal enable combination seen
// peak_level             out  DATA_W   see CONFIGURATION
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state IDLE, offset=0; des_ready, ser_valid, mem_we, mem_re,
//   seconds2, seq_err = 0; ser_data, mem_wdata, mem_addr, peak_level = 0. Reset mid-transfer
//   abandons it with no seconds2 pulse.
// - Handshake: transfer occurs on a cycle where valid && ready. ser_valid, once high, holds
//   ser_data stable until ser_ready is sampled.
// - States: IDLE, REC, RD_ISSUE, RD_WAIT, PLAY_OUT, DONE, RELEASE.
// - IDLE: timer&&deseriena&&!seriena&&memoryselect_clip_1[0] -> REC;
//   timer&&seriena&&!deseriena&&!memoryselect_clip_1[0] -> RD_ISSUE. Block latched on entry.
//   timer=1 with any other enable/select combination -> seq_err<=1 and RELEASE.
// - REC: des_ready=1. On des transfer: mem_we=1 same cycle (combinational from handshake),
//   mem_addr={blk,offset}, mem_wdata=des_data; offset++.
// - RD_ISSUE: mem_re=1 @ {blk,offset} for 1 cycle -> RD_WAIT (capture mem_rdata into ser_data) -> PLAY_OUT.
// - PLAY_OUT: ser_valid=1 until transfer; then offset++ and -> RD_ISSUE.
// - Completion: the transfer that moves sample CLIP_SAMPLES-1 goes to DONE (offset cleared);
//   no access to offset>=CLIP_SAMPLES is ever issued.
// - DONE: seconds2=1 for exactly one cycle -> RELEASE.
// - RELEASE: all strobes low; wait for timer=0 -> IDLE. Prevents re-arming while the
//   controller leaves its session state.
// - Abort: timer=0 in REC/RD_*/PLAY_OUT -> IDLE next cycle; offset=0; no seconds2; an
//   in-flight ser_valid is dropped.
// - Simultaneous: timer fall on the completing transfer cycle -> transfer completes, no pulse.
// - seq_err clears only on reset.
// CONFIGURATION
// CLIP_PEAK_EN defined: during REC, peak_level tracks max unsigned des_data over transferred
//   samples; cleared to 0 on REC entry; held after the clip for level meter.
// CLIP_PEAK_EN undefined: peak_level is constant 0; no tracking logic is built.
// TESTING (bench overrides CLIP_SAMPLES=4)
// - Record blk1: sel=2'b11, deseriena=1, timer=1, des_data 0x10,0x20,0x30,0x40 with des_valid
//   always high -> mem_we at addrs {1,0..3} with those data; seconds2 one cycle after 4th write.
// - Play blk0 preloaded 0xA1..0xA4, ser_ready toggling 1/0 -> ser_data A1,A2,A3,A4 in order,
//   each held while ready=0; seconds2 exactly once; mem_re at {0,0..3}, 1 cycle before capture.
// - Abort: timer drops after 2 of 4 recorded samples -> IDLE next cycle, no seconds2; new
//   session writes from offset 0.
// - Illegal: timer=1, seriena=deseriena=1 -> seq_err=1, no mem_we/mem_re; stays in RELEASE
//   until timer=0.
// - reset_n=0 mid-play with ser_valid=1 -> all outputs 0 next cycle, state IDLE.
// - CLIP_PEAK_EN build: record 0x05,0xF0,0x30,0x10 -> peak_level=0xF0; without macro -> 0.

Source files
------------

// File: rtl/clip_mem_sequencer.sv
// clip_mem_sequencer: moves one clip of samples between des/ser and clip memory, pulses seconds2 on completion
// Ports:
//   clock, reset_n           rising-edge clock, synchronous active-low reset
//   timer                    session active from controller
//   memoryselect_clip_1      [1] clip block, [0] 1=record 0=play
//   seriena, deseriena       play / record session enables
//   des_valid/ready/data     deserializer sample handshake
//   ser_valid/ready/data     serializer sample handshake
//   mem_addr/we/wdata/re/rdata  clip memory port, rdata one cycle after mem_re
//   seconds2                 one-cycle clip-complete pulse
//   seq_err                  sticky illegal-enable flag
//   peak_level               max recorded sample when CLIP_PEAK_EN is defined, else 0
module clip_mem_sequencer #(
    parameter int DATA_W       = 8,
    parameter int OFS_W        = 14,
    parameter int CLIP_SAMPLES = 16000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              timer,
    input  logic [1:0]        memoryselect_clip_1,
    input  logic              seriena,
    input  logic              deseriena,
    input  logic              des_valid,
    output logic              des_ready,
    input  logic [DATA_W-1:0] des_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic [DATA_W-1:0] ser_data,
    output logic [OFS_W:0]    mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              seconds2,
    output logic              seq_err,
    output logic [DATA_W-1:0] peak_level
);
    typedef enum logic [2:0] {IDLE, REC, RD_ISSUE, RD_WAIT, PLAY_OUT, DONE, RELEASE} state_t;
    localparam logic [OFS_W-1:0] LAST = OFS_W'(CLIP_SAMPLES - 1);
    state_t           state;
    logic             blk;
    logic [OFS_W-1:0] offset;
    logic             rec_go;
    logic             play_go;
    always_comb begin
        rec_go    = timer && deseriena && !seriena && memoryselect_clip_1[0];
        play_go   = timer && seriena && !deseriena && !memoryselect_clip_1[0];
        des_ready = state == REC;
        ser_valid = state == PLAY_OUT;
        seconds2  = state == DONE;
        mem_re    = state == RD_ISSUE;
        mem_we    = des_ready && des_valid;
        mem_addr  = (mem_we || mem_re) ? {blk, offset} : '0;
        mem_wdata = mem_we ? des_data : '0;
    end
    // A transfer on the same cycle timer falls still completes, but the
    // abort path wins so no seconds2 pulse is produced.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            blk      <= 1'b0;
            offset   <= '0;
            ser_data <= '0;
            seq_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rec_go) begin
                        state <= REC;
                        blk   <= memoryselect_clip_1[1];
                    end else if (play_go) begin
                        state <= RD_ISSUE;
                        blk   <= memoryselect_clip_1[1];
                    end else if (timer) begin
                        seq_err <= 1'b1;
                        state   <= RELEASE;
                    end
                end
                REC: begin
                    if (!timer) begin
                        state  <= IDLE;
                        offset <= '0;
                    end else if (des_valid) begin
                        offset <= (offset == LAST) ? '0 : offset + 1'b1;
                        state  <= (offset == LAST) ? DONE : REC;
                    end
                end
                RD_ISSUE: begin
                    state  <= timer ? RD_WAIT : IDLE;
                    offset <= timer ? offset : '0;
                end
                RD_WAIT: begin
                    ser_data <= mem_rdata;
                    state    <= timer ? PLAY_OUT : IDLE;
                    offset   <= timer ? offset : '0;
                end
                PLAY_OUT: begin
                    if (!timer) begin
                        state  <= IDLE;
                        offset <= '0;
                    end else if (ser_ready) begin
                        offset <= (offset == LAST) ? '0 : offset + 1'b1;
                        state  <= (offset == LAST) ? DONE : RD_ISSUE;
                    end
                end
                DONE:    state <= RELEASE;
                RELEASE: state <= timer ? RELEASE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CLIP_PEAK_EN
    always_ff @(posedge clock) begin
        if (!reset_n)
            peak_level <= '0;
        else if (state == IDLE && rec_go)
            peak_level <= '0;
        else if (mem_we && des_data > peak_level)
            peak_level <= des_data;
    end
`else
    assign peak_level = '0;
`endif
endmodule

// File: tb/tb_clip_mem_sequencer.sv
// tb_clip_mem_sequencer: table-driven check of record, play, abort, illegal, peak and reset behaviour
module tb_clip_mem_sequencer;
    localparam int DW = 8;
    localparam int OW = 14;
`ifdef CLIP_PEAK_EN
    localparam logic [7:0] PK = 8'hF0;
`else
    localparam logic [7:0] PK = 8'h00;
`endif
    logic          clock = 1'b0;
    logic          reset_n;
    logic          timer;
    logic [1:0]    sel;
    logic          seriena;
    logic          deseriena;
    logic          des_valid;
    logic          des_ready;
    logic [DW-1:0] des_data;
    logic          ser_valid;
    logic          ser_ready;
    logic [DW-1:0] ser_data;
    logic [OW:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          seconds2;
    logic          seq_err;
    logic [DW-1:0] peak_level;
    always #5 clock = ~clock;
    clip_mem_sequencer #(.DATA_W(DW), .OFS_W(OW), .CLIP_SAMPLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .timer(timer), .memoryselect_clip_1(sel),
        .seriena(seriena), .deseriena(deseriena), .des_valid(des_valid), .des_ready(des_ready),
        .des_data(des_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_data(ser_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .seconds2(seconds2), .seq_err(seq_err), .peak_level(peak_level)
    );
    logic [7:0] tmem [0:31];
    always @(posedge clock) begin
        if (mem_we) tmem[{mem_addr[OW], mem_addr[3:0]}] <= mem_wdata;
        if (mem_re) mem_rdata <= tmem[{mem_addr[OW], mem_addr[3:0]}];
    end
    logic [36:0] obs;
    assign obs = {des_ready, mem_we, mem_addr, mem_wdata, mem_re, ser_valid, ser_data, seconds2, seq_err};
    typedef struct {
        logic        t;
        logic [1:0]  s;
        logic        se;
        logic        de;
        logic        dv;
        logic [7:0]  dd;
        logic        sr;
        logic [36:0] exp;
    } vec_t;
    vec_t vq[$];
    int checks = 0;
    int errors = 0;
    bit seen;
    function automatic void add(input logic t, input logic [1:0] s, input logic se, input logic de,
                                input logic dv, input logic [7:0] dd, input logic sr,
                                input logic dr, input logic we, input logic [14:0] a, input logic [7:0] wd,
                                input logic re, input logic sv, input logic [7:0] sd, input logic s2,
                                input logic er);
        vec_t v;
        v.t = t; v.s = s; v.se = se; v.de = de; v.dv = dv; v.dd = dd; v.sr = sr;
        v.exp = {dr, we, a, wd, re, sv, sd, s2, er};
        vq.push_back(v);
    endfunction
    task automatic chk(input string nm, input logic [36:0] got, input logic [36:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask
    initial begin
        for (int i = 0; i < 32; i++) tmem[i] = 8'h00;
        tmem[0] = 8'hA1; tmem[1] = 8'hA2; tmem[2] = 8'hA3; tmem[3] = 8'hA4;
        // record block 1
        add(1,3,0,1,1,8'h10,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        add(1,3,0,1,1,8'h10,0, 1,1,15'h4000,8'h10,0,0,8'h00,0,0);
        add(1,3,0,1,1,8'h20,0, 1,1,15'h4001,8'h20,0,0,8'h00,0,0);
        add(1,3,0,1,1,8'h30,0, 1,1,15'h4002,8'h30,0,0,8'h00,0,0);
        add(1,3,0,1,1,8'h40,0, 1,1,15'h4003,8'h40,0,0,8'h00,0,0);
        add(1,3,0,1,1,8'h40,0, 0,0,15'h0000,8'h00,0,0,8'h00,1,0);
        add(1,3,0,1,1,8'h40,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        add(0,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        add(0,0,0,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        // play block 0 with ready low on the first PLAY_OUT cycle of each sample
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,1,0,8'h00,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'h00,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,1,8'hA1,0,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,1,8'hA1,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0001,8'h00,1,0,8'hA1,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA1,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,1,8'hA2,0,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,1,8'hA2,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0002,8'h00,1,0,8'hA2,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA2,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,1,8'hA3,0,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,1,8'hA3,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0003,8'h00,1,0,8'hA3,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA3,0,0);
        add(1,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,1,8'hA4,0,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,1,8'hA4,0,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,0,8'hA4,1,0);
        add(1,0,1,0,0,8'h00,1, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(0,0,1,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        // abort after two samples, then restart from offset 0
        add(1,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h55,0, 1,1,15'h4000,8'h55,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h66,0, 1,1,15'h4001,8'h66,0,0,8'hA4,0,0);
        add(0,3,0,1,0,8'h00,0, 1,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(0,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h77,0, 1,1,15'h4000,8'h77,0,0,8'hA4,0,0);
        add(0,3,0,1,0,8'h00,0, 1,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(0,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        // peak session with one stalled cycle
        add(1,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h05,0, 1,1,15'h4000,8'h05,0,0,8'hA4,0,0);
        add(1,3,0,1,0,8'hEE,0, 1,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'hF0,0, 1,1,15'h4001,8'hF0,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h30,0, 1,1,15'h4002,8'h30,0,0,8'hA4,0,0);
        add(1,3,0,1,1,8'h10,0, 1,1,15'h4003,8'h10,0,0,8'hA4,0,0);
        add(1,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,1,0);
        add(0,3,0,1,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        // illegal enables
        add(1,0,1,1,1,8'h99,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,0);
        add(1,0,1,1,1,8'h99,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,1);
        add(1,0,1,1,1,8'h99,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,1);
        add(0,0,1,1,1,8'h99,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,1);
        add(0,0,0,0,0,8'h00,0, 0,0,15'h0000,8'h00,0,0,8'hA4,0,1);
        reset_n = 1'b0; timer = 0; sel = 0; seriena = 0; deseriena = 0;
        des_valid = 0; des_data = 0; ser_ready = 0;
        repeat (2) @(posedge clock);
        #1 chk("reset", obs, 37'd0);
        chk("reset_peak", 37'(peak_level), 37'd0);
        @(negedge clock) reset_n = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            timer = vq[i].t; sel = vq[i].s; seriena = vq[i].se; deseriena = vq[i].de;
            des_valid = vq[i].dv; des_data = vq[i].dd; ser_ready = vq[i].sr;
            #1 chk($sformatf("vec%0d", i), obs, vq[i].exp);
        end
        chk("peak_held", 37'(peak_level), 37'(PK));
        @(negedge clock);
        timer = 1; sel = 0; seriena = 1; deseriena = 0; des_valid = 0; ser_ready = 0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            #1;
            if (ser_valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL play_start got ser_valid 0 exp 1");
        end
        chk("pre_reset_data", 37'(ser_data), 37'(8'hA1));
        reset_n = 1'b0;
        @(posedge clock);
        #1 chk("rst_midplay", obs, 37'd0);
        chk("rst_midplay_peak", 37'(peak_level), 37'd0);
        @(negedge clock);
        reset_n = 1'b1; timer = 0;
        @(posedge clock);
        #1 chk("post_reset", obs, 37'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
